// File: rtl/thermal_frame_reader_if.sv
// rtl/thermal_frame_reader_if.sv - byte-level I2C controller bus between the frame reader and the controller
//
// Purpose: groups the signals exchanged with the downstream byte-level I2C
// controller. The master modport is the frame reader and the slave modport is
// the controller.
// Signals:
//   i2c_address       reader -> ctrl  8-bit device address
//   i2c_write_mode    reader -> ctrl  1 = write, 0 = read
//   i2c_tx_data       reader -> ctrl  byte to transmit
//   i2c_write_pending reader -> ctrl  more write bytes follow
//   i2c_start         reader -> ctrl  one-cycle transfer start
//   i2c_busy          ctrl -> reader  controller busy, falling edge = byte boundary
//   i2c_rx_data       ctrl -> reader  received byte
//   i2c_read_pending  ctrl -> reader  peripheral has more data to send
interface thermal_frame_reader_if;
  logic [7:0] i2c_address;
  logic       i2c_write_mode;
  logic [7:0] i2c_tx_data;
  logic       i2c_write_pending;
  logic       i2c_start;
  logic       i2c_busy;
  logic [7:0] i2c_rx_data;
  logic       i2c_read_pending;

  modport master (
    output i2c_address, i2c_write_mode, i2c_tx_data, i2c_write_pending, i2c_start,
    input  i2c_busy, i2c_rx_data, i2c_read_pending
  );

  modport slave (
    input  i2c_address, i2c_write_mode, i2c_tx_data, i2c_write_pending, i2c_start,
    output i2c_busy, i2c_rx_data, i2c_read_pending
  );
endinterface

// File: rtl/thermal_frame_reader.sv
// rtl/thermal_frame_reader.sv - burst reader of 16-bit words from a thermal sensor over a byte-level I2C controller
//
// Purpose: on cmd_start, writes the 16-bit register address (high byte first),
// waits for the write transaction to end, then reads cmd_count big-endian
// 16-bit words and streams them through a 4-entry FIFO together with their
// index in the burst. Detects controller timeouts, short reads and FIFO
// overflow.
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   cmd_start/cmd_reg/cmd_count command request (accepted in IDLE only)
//   cmd_busy                   command in progress
//   out_data/out_index/out_valid/out_ready  word stream to the consumer
//   done                       one-cycle pulse on successful completion
//   err/err_code               sticky error flag and cause (1 timeout, 2 short read, 3 overflow)
//   i2c                        master side of the I2C controller bus
module thermal_frame_reader #(
  parameter logic [7:0] DEV_ADDR = 8'h66,
  parameter int         TIMEOUT  = 1024,
  parameter int         STOP_GAP = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_start,
  input  logic [15:0] cmd_reg,
  input  logic [9:0]  cmd_count,
  output logic        cmd_busy,
  output logic [15:0] out_data,
  output logic [9:0]  out_index,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        done,
  output logic        err,
  output logic [1:0]  err_code,
  thermal_frame_reader_if.master i2c
);

  localparam int            TW    = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] T_LIM = TW'(TIMEOUT - 1);
  localparam int            GW    = $clog2(STOP_GAP + 1);
  localparam logic [GW-1:0] G_LIM = GW'(STOP_GAP - 1);

  localparam logic [1:0] E_TIMEOUT  = 2'd1;
  localparam logic [1:0] E_SHORT    = 2'd2;
  localparam logic [1:0] E_OVERFLOW = 2'd3;

  typedef enum logic [3:0] {
    IDLE, W_START, W_HI, W_LO, W_END, R_START, R_HI, R_LO, DRAIN, DONE, ERROR
  } state_t;

  state_t        state, state_q;
  logic [15:0]   reg_q;
  logic [9:0]    count_q;
  logic [9:0]    idx_q;
  logic [7:0]    word_hi_q;
  logic          busy_q;
  logic [TW-1:0] tcnt;
  logic [GW-1:0] gap_cnt;
  logic          start_q, wmode_q, wpend_q;
  logic [7:0]    tx_q;

  logic [15:0]   fifo_data [4];
  logic [9:0]    fifo_idx  [4];
  logic [1:0]    wr_ptr, rd_ptr;
  logic [2:0]    fifo_cnt;

  logic [9:0]    count_eff;
  logic          busy_fall, busy_chg, state_chg, active, tmo;
  logic          pop, push_req, push_ok, overflow, last_word;

  assign i2c.i2c_address       = DEV_ADDR;
  assign i2c.i2c_start         = start_q;
  assign i2c.i2c_write_mode    = wmode_q;
  assign i2c.i2c_tx_data       = tx_q;
  assign i2c.i2c_write_pending = wpend_q;

  always_comb begin
    count_eff = cmd_count;
    if (cmd_count == 10'd0)
      count_eff = 10'd1;
    else if (cmd_count > 10'd768)
      count_eff = 10'd768;
  end

  assign busy_fall = busy_q & ~i2c.i2c_busy;
  assign busy_chg  = busy_q ^ i2c.i2c_busy;
  assign state_chg = (state != state_q);
  assign active    = (state != IDLE) && (state != DONE) && (state != ERROR);
  // The counter is cleared on the cycle after any busy edge or state change,
  // so a stalled state fires after TIMEOUT unchanged cycles.
  assign tmo       = active && !busy_chg && !state_chg && (tcnt == T_LIM);

  // The head entry is masked to zero when empty so the outputs read as zero
  // straight out of reset without resetting the storage array.
  assign out_valid = (fifo_cnt != 3'd0);
  assign out_data  = out_valid ? fifo_data[rd_ptr] : 16'h0000;
  assign out_index = out_valid ? fifo_idx[rd_ptr]  : 10'd0;

  assign pop       = out_valid & out_ready;
  assign push_req  = (state == R_LO) && busy_fall;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign push_ok   = push_req && ((fifo_cnt != 3'd4) || pop);
  assign overflow  = push_req && !push_ok;
  assign last_word = ((idx_q + 10'd1) == count_q);

  always_ff @(posedge clk) begin
    if (push_ok) begin
      fifo_data[wr_ptr] <= {word_hi_q, i2c.i2c_rx_data};
      fifo_idx[wr_ptr]  <= idx_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      state_q   <= IDLE;
      reg_q     <= 16'h0000;
      count_q   <= 10'd0;
      idx_q     <= 10'd0;
      word_hi_q <= 8'h00;
      busy_q    <= 1'b0;
      tcnt      <= '0;
      gap_cnt   <= '0;
      start_q   <= 1'b0;
      wmode_q   <= 1'b0;
      wpend_q   <= 1'b0;
      tx_q      <= 8'h00;
      wr_ptr    <= 2'd0;
      rd_ptr    <= 2'd0;
      fifo_cnt  <= 3'd0;
      cmd_busy  <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      err_code  <= 2'd0;
    end else begin
      start_q <= 1'b0;
      done    <= 1'b0;
      busy_q  <= i2c.i2c_busy;
      state_q <= state;

      if (busy_chg || state_chg)
        tcnt <= '0;
      else if (tcnt != T_LIM)
        tcnt <= tcnt + TW'(1);

      if (push_ok)
        wr_ptr <= wr_ptr + 2'd1;
      if (pop)
        rd_ptr <= rd_ptr + 2'd1;
      fifo_cnt <= fifo_cnt + 3'(push_ok) - 3'(pop);

      if (tmo) begin
        state    <= ERROR;
        err      <= 1'b1;
        err_code <= E_TIMEOUT;
        wpend_q  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (cmd_start) begin
              reg_q    <= cmd_reg;
              count_q  <= count_eff;
              idx_q    <= 10'd0;
              err      <= 1'b0;
              err_code <= 2'd0;
              cmd_busy <= 1'b1;
              state    <= W_START;
            end
          end
          W_START: begin
            if (!i2c.i2c_busy) begin
              start_q <= 1'b1;
              wmode_q <= 1'b1;
              tx_q    <= reg_q[15:8];
              wpend_q <= 1'b1;
              state   <= W_HI;
            end
          end
          W_HI: begin
            if (busy_fall) begin
              tx_q  <= reg_q[7:0];
              state <= W_LO;
            end
          end
          W_LO: begin
            if (busy_fall) begin
              wpend_q <= 1'b0;
              gap_cnt <= '0;
              state   <= W_END;
            end
          end
          W_END: begin
            // The write transaction is over once busy has stayed low for
            // STOP_GAP consecutive cycles.
            if (i2c.i2c_busy)
              gap_cnt <= '0;
            else if (gap_cnt == G_LIM)
              state <= R_START;
            else
              gap_cnt <= gap_cnt + GW'(1);
          end
          R_START: begin
            start_q <= 1'b1;
            wmode_q <= 1'b0;
            state   <= R_HI;
          end
          R_HI: begin
            if (busy_fall) begin
              word_hi_q <= i2c.i2c_rx_data;
              // The low byte of this word is always still owed here.
              if (!i2c.i2c_read_pending) begin
                state    <= ERROR;
                err      <= 1'b1;
                err_code <= E_SHORT;
              end else begin
                state <= R_LO;
              end
            end
          end
          R_LO: begin
            if (busy_fall) begin
              if (overflow) begin
                state    <= ERROR;
                err      <= 1'b1;
                err_code <= E_OVERFLOW;
              end else begin
                idx_q <= idx_q + 10'd1;
                if (last_word)
                  state <= DRAIN;
                else if (!i2c.i2c_read_pending) begin
                  state    <= ERROR;
                  err      <= 1'b1;
                  err_code <= E_SHORT;
                end else
                  state <= R_HI;
              end
            end
          end
          DRAIN: begin
            if (fifo_cnt == 3'd0) begin
              done  <= 1'b1;
              state <= DONE;
            end
          end
          DONE: begin
            cmd_busy <= 1'b0;
            state    <= IDLE;
          end
          ERROR: begin
            err     <= 1'b1;
            wpend_q <= 1'b0;
            if ((fifo_cnt == 3'd0) && !i2c.i2c_busy) begin
              cmd_busy <= 1'b0;
              state    <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_thermal_frame_reader.sv
// tb/tb_thermal_frame_reader.sv - self-checking bench for thermal_frame_reader with an I2C controller model
module tb_thermal_frame_reader;
  localparam int BYTE_CYC = 6;
  localparam int GAP      = 2;
  localparam int STALL    = 1100;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_start;
  logic [15:0] cmd_reg;
  logic [9:0]  cmd_count;
  logic        cmd_busy;
  logic [15:0] out_data;
  logic [9:0]  out_index;
  logic        out_valid;
  logic        out_ready;
  logic        done;
  logic        err;
  logic [1:0]  err_code;

  thermal_frame_reader_if bus();

  thermal_frame_reader dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_start (cmd_start),
    .cmd_reg   (cmd_reg),
    .cmd_count (cmd_count),
    .cmd_busy  (cmd_busy),
    .out_data  (out_data),
    .out_index (out_index),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .done      (done),
    .err       (err),
    .err_code  (err_code),
    .i2c       (bus)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [7:0]  rd_bytes[$];
  logic [7:0]  ref_b[$];
  logic [7:0]  wr_log[$];
  logic [15:0] got_d[$];
  logic [9:0]  got_i[$];
  int          bytes_read;
  int          drop_after = -1;
  int          stall_at   = -1;
  int          m_phase;
  int          m_left;
  logic        m_write;
  logic        m_more;
  logic        ready_mode = 1'b1;
  int          done_cnt = 0;
  int          start_cnt = 0;
  int          start_err_cnt = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int byte_len();
    return (!m_write && (bytes_read + 1 == stall_at)) ? STALL : BYTE_CYC;
  endfunction

  // Byte-level controller model: each byte keeps busy high for a while, then
  // drops it for a short gap; write bytes are sampled at their start.
  initial begin
    bus.i2c_busy = 1'b0;
    bus.i2c_rx_data = 8'h00;
    bus.i2c_read_pending = 1'b0;
    m_phase = 0; m_left = 0; m_write = 1'b0; m_more = 1'b0; bytes_read = 0;
    forever begin
      @(negedge clk);
      case (m_phase)
        0: if (bus.i2c_start) begin
          m_write = bus.i2c_write_mode;
          if (m_write) begin
            wr_log.push_back(bus.i2c_tx_data);
            bytes_read = 0;
          end
          bus.i2c_busy = 1'b1;
          m_left = byte_len();
          m_phase = 1;
        end
        1: begin
          m_left--;
          if (m_left == 0) begin
            bus.i2c_busy = 1'b0;
            if (!m_write) begin
              bus.i2c_rx_data = (rd_bytes.size() != 0) ? rd_bytes.pop_front() : 8'hFF;
              bytes_read++;
              m_more = (rd_bytes.size() != 0) && (bytes_read != drop_after);
              bus.i2c_read_pending = m_more;
            end
            m_left = GAP;
            m_phase = 2;
          end
        end
        default: begin
          m_left--;
          if (m_left == 0) begin
            if (m_write ? bus.i2c_write_pending : m_more) begin
              if (m_write) wr_log.push_back(bus.i2c_tx_data);
              bus.i2c_busy = 1'b1;
              m_left = byte_len();
              m_phase = 1;
            end else begin
              m_phase = 0;
            end
          end
        end
      endcase
    end
  end

  // Consumer and event monitor.
  initial begin
    out_ready = 1'b0;
    forever begin
      @(negedge clk);
      out_ready = ready_mode;
      #1;
      if (out_valid && out_ready && !reset) begin
        got_d.push_back(out_data);
        got_i.push_back(out_index);
      end
      if (done) done_cnt++;
      if (bus.i2c_start) begin
        start_cnt++;
        if (err) start_err_cnt++;
      end
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clear_logs();
    got_d.delete(); got_i.delete(); wr_log.delete();
    done_cnt = 0; start_err_cnt = 0;
    drop_after = -1; stall_at = -1;
  endtask

  task automatic load_bytes(input int n, input bit fixed);
    rd_bytes.delete(); ref_b.delete();
    for (int i = 0; i < n; i++) begin
      logic [7:0] b;
      b = fixed ? 8'((i + 1) * 8'h11) : 8'($urandom);
      rd_bytes.push_back(b);
      ref_b.push_back(b);
    end
  endtask

  task automatic pulse_start(input logic [15:0] r, input logic [9:0] c);
    @(negedge clk);
    cmd_reg = r; cmd_count = c; cmd_start = 1'b1;
    @(negedge clk);
    cmd_start = 1'b0;
  endtask

  task automatic wait_quiet(input string tag, input int limit);
    int c = 0;
    while ((cmd_busy || m_phase != 0) && c < limit) begin
      @(negedge clk);
      c++;
    end
    check({tag, "_finished"}, 32'(c < limit), 32'd1);
    repeat (4) @(negedge clk);
  endtask

  task automatic wait_err(input string tag, input int limit);
    int c = 0;
    while (!err && c < limit) begin
      @(negedge clk);
      c++;
    end
    check({tag, "_err_seen"}, 32'(err), 32'd1);
  endtask

  // Expected word i is {byte 2i, byte 2i+1} with index i.
  task automatic check_words(input string tag, input int k);
    check({tag, "_nwords"}, 32'(got_d.size()), 32'(k));
    for (int i = 0; i < k && i < got_d.size(); i++) begin
      check({tag, "_data"}, 32'(got_d[i]), 32'({ref_b[2*i], ref_b[2*i+1]}));
      check({tag, "_index"}, 32'(got_i[i]), 32'(i));
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cmd_busy"}, 32'(cmd_busy), 32'd0);
    check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_err"}, 32'(err), 32'd0);
    check({tag, "_err_code"}, 32'(err_code), 32'd0);
    check({tag, "_i2c_start"}, 32'(bus.i2c_start), 32'd0);
    check({tag, "_wpend"}, 32'(bus.i2c_write_pending), 32'd0);
    check({tag, "_wmode"}, 32'(bus.i2c_write_mode), 32'd0);
    check({tag, "_tx"}, 32'(bus.i2c_tx_data), 32'd0);
    check({tag, "_out_data"}, 32'(out_data), 32'd0);
    check({tag, "_out_index"}, 32'(out_index), 32'd0);
  endtask

  initial begin
    int snap;
    int c;
    int cnt;
    logic [15:0] r;
    reset = 1'b1; cmd_start = 1'b0; cmd_reg = 16'h0; cmd_count = 10'd0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    check("reset_addr", 32'(bus.i2c_address), 32'h66);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Burst read with fixed bytes 11..66.
    clear_logs(); load_bytes(6, 1'b1); ready_mode = 1'b1;
    pulse_start(16'h2400, 10'd3);
    wait_quiet("burst", 3000);
    check("burst_nwr", 32'(wr_log.size()), 32'd2);
    if (wr_log.size() == 2) begin
      check("burst_wr0", 32'(wr_log[0]), 32'h24);
      check("burst_wr1", 32'(wr_log[1]), 32'h00);
    end
    check_words("burst", 3);
    check("burst_done", 32'(done_cnt), 32'd1);
    check("burst_err", 32'(err), 32'd0);

    // Random bursts.
    for (int t = 0; t < 3; t++) begin
      cnt = int'($urandom_range(2, 7));
      r = 16'($urandom);
      clear_logs(); load_bytes(2 * cnt, 1'b0);
      pulse_start(r, 10'(cnt));
      wait_quiet("rand", 4000);
      check("rand_nwr", 32'(wr_log.size()), 32'd2);
      if (wr_log.size() == 2) begin
        check("rand_wr0", 32'(wr_log[0]), 32'(r[15:8]));
        check("rand_wr1", 32'(wr_log[1]), 32'(r[7:0]));
      end
      check_words("rand", cnt);
      check("rand_done", 32'(done_cnt), 32'd1);
    end

    // Backpressure: four words fit in the FIFO.
    clear_logs(); load_bytes(8, 1'b0); ready_mode = 1'b0;
    pulse_start(16'h0800, 10'd4);
    c = 0;
    while (!(bytes_read == 8 && m_phase == 0) && c < 3000) begin
      @(negedge clk);
      c++;
    end
    repeat (20) @(negedge clk);
    check("bp_no_err", 32'(err), 32'd0);
    check("bp_valid", 32'(out_valid), 32'd1);
    check("bp_nothing_popped", 32'(got_d.size()), 32'd0);
    ready_mode = 1'b1;
    wait_quiet("bp", 2000);
    check_words("bp", 4);
    check("bp_err", 32'(err), 32'd0);
    check("bp_done", 32'(done_cnt), 32'd1);

    // Overflow: the fifth word has nowhere to go.
    clear_logs(); load_bytes(10, 1'b0); ready_mode = 1'b0;
    pulse_start(16'h0900, 10'd5);
    wait_err("ovf", 3000);
    check("ovf_code", 32'(err_code), 32'd3);
    check("ovf_busy_held", 32'(cmd_busy), 32'd1);
    ready_mode = 1'b1;
    wait_quiet("ovf", 2000);
    check_words("ovf", 4);
    check("ovf_busy_after", 32'(cmd_busy), 32'd0);
    check("ovf_no_done", 32'(done_cnt), 32'd0);

    // Short read: read_pending drops after the second byte.
    clear_logs(); load_bytes(4, 1'b0); drop_after = 2;
    pulse_start(16'h0A00, 10'd2);
    wait_quiet("short", 3000);
    check("short_err", 32'(err), 32'd1);
    check("short_code", 32'(err_code), 32'd2);
    check_words("short", 1);
    check("short_busy", 32'(cmd_busy), 32'd0);
    check("short_no_done", 32'(done_cnt), 32'd0);

    // Timeout: the first read byte stalls past TIMEOUT.
    clear_logs(); load_bytes(2, 1'b0); stall_at = 1;
    pulse_start(16'h0B00, 10'd1);
    wait_err("tmo", 1500);
    check("tmo_code", 32'(err_code), 32'd1);
    wait_quiet("tmo", 3000);
    check("tmo_no_start_in_err", 32'(start_err_cnt), 32'd0);
    check("tmo_no_words", 32'(got_d.size()), 32'd0);
    check("tmo_no_done", 32'(done_cnt), 32'd0);

    // cmd_count = 0 is treated as a single word.
    clear_logs(); load_bytes(2, 1'b0);
    pulse_start(16'h0C00, 10'd0);
    wait_quiet("cnt0", 3000);
    check_words("cnt0", 1);
    check("cnt0_done", 32'(done_cnt), 32'd1);
    check("cnt0_err", 32'(err), 32'd0);

    // cmd_count above 768 is clamped to a full 768-word frame.
    clear_logs(); load_bytes(1536, 1'b0);
    pulse_start(16'h0D00, 10'd1000);
    wait_quiet("clamp", 20000);
    check_words("clamp", 768);
    check("clamp_done", 32'(done_cnt), 32'd1);
    check("clamp_err", 32'(err), 32'd0);

    // A second command during a burst is ignored.
    clear_logs(); load_bytes(4, 1'b0);
    pulse_start(16'h1234, 10'd2);
    repeat (5) @(negedge clk);
    check("ign_busy", 32'(cmd_busy), 32'd1);
    pulse_start(16'hABCD, 10'd5);
    wait_quiet("ign", 3000);
    check("ign_nwr", 32'(wr_log.size()), 32'd2);
    if (wr_log.size() == 2) begin
      check("ign_wr0", 32'(wr_log[0]), 32'h12);
      check("ign_wr1", 32'(wr_log[1]), 32'h34);
    end
    check_words("ign", 2);
    check("ign_done", 32'(done_cnt), 32'd1);

    // Reset while the second word's low byte is outstanding.
    clear_logs(); load_bytes(6, 1'b0);
    pulse_start(16'h5A5A, 10'd3);
    c = 0;
    while (bytes_read != 3 && c < 3000) begin
      @(negedge clk);
      c++;
    end
    check("rst_reached_rlo", 32'(bytes_read), 32'd3);
    @(negedge clk);
    reset = 1'b1; cmd_start = 1'b1; cmd_reg = 16'h7777; cmd_count = 10'd2;
    #1;
    check_reset_outputs("rst_mid");
    repeat (3) @(negedge clk);
    check("rst_held_busy", 32'(cmd_busy), 32'd0);
    check("rst_held_start", 32'(bus.i2c_start), 32'd0);
    reset = 1'b0; cmd_start = 1'b0;
    snap = start_cnt;
    c = 0;
    while (m_phase != 0 && c < 3000) begin
      @(negedge clk);
      c++;
    end
    repeat (50) @(negedge clk);
    check("rst_no_new_start", 32'(start_cnt), 32'(snap));
    check("rst_idle_busy", 32'(cmd_busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/thermal_frame_reader.md
THERMAL_FRAME_READER -- requirements
Module: thermal_frame_reader

Interface
REQ-001 SHALL have parameter DEV_ADDR, default 8'h66, 8-bit sensor bus address with LSB ignored.
REQ-002 SHALL have parameter TIMEOUT, default 1024, the maximum number of clk cycles that i2c_busy may stay unchanged before an error is raised.
REQ-003 SHALL have parameter STOP_GAP, default 4, the number of consecutive cycles with i2c_busy low that marks a transaction as ended.
REQ-004 Ports (name, direction, width, meaning):
- clk, in, 1: clock, the same domain as the downstream byte-level I2C controller.
- reset, in, 1: asynchronous, active-high.
- cmd_start, in, 1: one-cycle request; accepted only while in IDLE.
- cmd_reg, in, 16: sensor register address of the first word.
- cmd_count, in, 10: number of 16-bit words to read, 1..768.
- cmd_busy, out, 1: high from command accept until DONE or ERROR is exited.
- out_data, out, 16: assembled word.
- out_index, out, 10: word number within the burst, starting at 0.
- out_valid, out, 1: out_data and out_index are valid.
- out_ready, in, 1: consumer accepts the word.
- done, out, 1: one-cycle pulse when the burst completes successfully.
- err, out, 1: sticky error flag, cleared by the next cmd_start.
- err_code, out, 2: 0 = none, 1 = timeout, 2 = short read, 3 = overflow.
- i2c_address, out, 8: driven with DEV_ADDR.
- i2c_write_mode, out, 1: 1 = write, 0 = read.
- i2c_tx_data, out, 8: byte to transmit.
- i2c_write_pending, out, 1: more write bytes follow.
- i2c_start, out, 1: one-cycle transfer start.
- i2c_busy, in, 1: controller busy; a 1->0 edge marks a byte boundary.
- i2c_rx_data, in, 8: received byte.
- i2c_read_pending, in, 1: the peripheral has more data to send.

Function
REQ-005 SHALL implement states IDLE, W_START, W_HI, W_LO, W_END, R_START, R_HI, R_LO, DRAIN, DONE, ERROR.
REQ-006 In IDLE with cmd_start=1, SHALL latch cmd_reg and cmd_count, clear err and err_code, set cmd_busy=1, and go to W_START.
- cmd_count=0 is treated as 1.
- cmd_count>768 is clamped to 768.
REQ-007 W_START: once i2c_busy=0, SHALL assert i2c_start for exactly one cycle, with i2c_write_mode=1, i2c_tx_data=cmd_reg[15:8] and i2c_write_pending=1, then go to W_HI.
REQ-008 W_HI: on an i2c_busy 1->0 edge, SHALL present i2c_tx_data=cmd_reg[7:0] with i2c_write_pending=1 held, then go to W_LO.
REQ-009 W_LO: on an i2c_busy 1->0 edge, SHALL drop i2c_write_pending to 0, then go to W_END.
REQ-010 W_END: after STOP_GAP consecutive cycles with i2c_busy=0, SHALL go to R_START.
REQ-011 R_START: SHALL pulse i2c_start for one cycle with i2c_write_mode=0, then go to R_HI.
REQ-012 R_HI: on an i2c_busy 1->0 edge, SHALL capture i2c_rx_data into word[15:8], then go to R_LO.
REQ-013 R_LO: on an i2c_busy 1->0 edge, SHALL capture word[7:0], push {word, index} into the output FIFO, and increment index (10-bit).
- If index+1 == count, go to DRAIN.
- Otherwise go to R_HI.
REQ-014 Short read: at any R_HI or R_LO byte edge with bytes remaining after this one and i2c_read_pending=0, SHALL go to ERROR with err_code=2.
REQ-015 The output FIFO SHALL be 4 entries deep, in first-in-first-out order, with out_valid = not empty.
- A pop occurs on a cycle with out_valid and out_ready both high.
- Simultaneous push and pop while full SHALL succeed.
REQ-016 A push to a full FIFO without a same-cycle pop SHALL drop the word and go to ERROR with err_code=3.
REQ-017 The timeout counter SHALL reset on every i2c_busy transition and on every state change.
- When it reaches TIMEOUT in any state other than IDLE, DONE or ERROR, SHALL go to ERROR with err_code=1.
REQ-018 DRAIN: SHALL wait for the FIFO to empty, then go to DONE.
REQ-019 DONE: SHALL pulse done=1 for one cycle, clear cmd_busy, then go to IDLE.
REQ-020 ERROR: SHALL set err=1 and hold i2c_start and i2c_write_pending low.
- The FIFO SHALL remain poppable.
- SHALL go to IDLE with cmd_busy=0 once the FIFO is empty and i2c_busy=0.
REQ-021 cmd_start outside IDLE SHALL be ignored.
REQ-022 i2c_address SHALL equal DEV_ADDR at all times.

Reset
REQ-023 Reset SHALL force IDLE and empty the FIFO, and drive the following outputs:
- cmd_busy, out_valid, done, err = 0.
- err_code = 0.
- i2c_start, i2c_write_pending, i2c_write_mode = 0.
- i2c_tx_data = 0.
- out_data, out_index = 0.
REQ-024 Reset asserted mid-burst SHALL abort immediately; after release no i2c_start is issued until a new cmd_start.

Verification
REQ-025 Burst read:
- Stimulus: cmd_reg=16'h2400, cmd_count=3; controller model returns 11 22 33 44 55 66 with read_pending high until the last byte; out_ready=1.
- Response: write bytes 24 then 00; words 1122/0, 3344/1, 5566/2; one done pulse.
REQ-026 Backpressure:
- Stimulus: cmd_count=4, out_ready=0 until after the 4th word, then out_ready=1.
- Response: 4 words delivered in order with no error; then cmd_count=5 with out_ready=0 gives err_code=3 after the 5th word.
REQ-027 Short read:
- Stimulus: cmd_count=2, model drops read_pending after byte 2.
- Response: err=1, err_code=2, word 0 still delivered, cmd_busy=0 afterwards.
REQ-028 Timeout:
- Stimulus: model holds i2c_busy=1 in R_HI for 1024 cycles.
- Response: err_code=1, with no i2c_start pulses during ERROR.
REQ-029 Reset mid-burst:
- Stimulus: reset asserted during R_LO.
- Response: all outputs at their reset values within the same cycle; cmd_start=1 ignored while reset=1.
REQ-030 Ignored command:
- Stimulus: cmd_start pulsed while cmd_busy=1.
- Response: latched cmd_reg and cmd_count unchanged; burst completes as originally commanded.
